// File: rtl/riscv_pkg.sv
// Shared RV32I memory-stage definitions: access-size encodings, LSU states,
// and the legality / store-lane helpers used by the load-store unit.
package riscv_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_RD
    } lsu_state_e;

    function automatic logic lsu_legal(input logic is_rd, input logic is_wr,
                                       input logic [2:0] f3, input logic [1:0] off);
        logic ok;
        ok = is_rd ^ is_wr;
        if (is_rd && !(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU})) ok = 1'b0;
        if (is_wr && !(f3 inside {F3_B, F3_H, F3_W})) ok = 1'b0;
        if ((f3 == F3_H || f3 == F3_HU) && off[0]) ok = 1'b0;
        if (f3 == F3_W && off != 2'b00) ok = 1'b0;
        return ok;
    endfunction

    function automatic logic [3:0] st_wstrb(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b00:   return 4'b0001 << off;
            2'b01:   return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] st_wdata(input logic [2:0] f3, input logic [31:0] rs2);
        case (f3[1:0])
            2'b00:   return {4{rs2[7:0]}};
            2'b01:   return {2{rs2[15:0]}};
            default: return rs2;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Selects the addressed byte/half of a loaded word and sign- or zero-extends it.
module lsu_load_extend
    import riscv_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  offset_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        case (offset_i)
            2'd0:    byte_v = rdata_i[7:0];
            2'd1:    byte_v = rdata_i[15:8];
            2'd2:    byte_v = rdata_i[23:16];
            default: byte_v = rdata_i[31:24];
        endcase
        half_v = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (funct3_i)
            F3_B:    data_o = {{24{byte_v[7]}}, byte_v};
            F3_H:    data_o = {{16{half_v[15]}}, half_v};
            F3_BU:   data_o = {24'b0, byte_v};
            F3_HU:   data_o = {16'b0, half_v};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// RV32I memory stage: issues loads/stores over a req/ready/rvalid port,
// stalls upstream while an access is outstanding, and registers MEM/WB results.
module mem_stage_lsu #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned REGADDR_W = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ex_valid,
    input  logic                 ex_mem_read,
    input  logic                 ex_mem_write,
    input  logic                 ex_mem_to_reg,
    input  logic                 ex_reg_write,
    input  logic [XLEN-1:0]      ex_alu_res,
    input  logic [XLEN-1:0]      ex_rs2_data,
    input  logic [REGADDR_W-1:0] ex_rd,
    input  logic [2:0]           ex_funct3,
    output logic                 stall_out,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic [XLEN-1:0]      dmem_addr,
    output logic [XLEN-1:0]      dmem_wdata,
    output logic [3:0]           dmem_wstrb,
    input  logic                 dmem_ready,
    input  logic                 dmem_rvalid,
    input  logic [XLEN-1:0]      dmem_rdata,
    output logic                 wb_valid,
    output logic                 wb_reg_write,
    output logic [REGADDR_W-1:0] wb_rd,
    output logic [XLEN-1:0]      wb_data,
    output logic                 access_exc,
    output logic [XLEN-1:0]      exc_addr
);
    import riscv_pkg::*;

    lsu_state_e           state_q;
    logic                 cap_we_q, cap_rw_q, cap_m2r_q;
    logic [XLEN-1:0]      cap_addr_q, cap_wdata_q;
    logic [3:0]           cap_wstrb_q;
    logic [REGADDR_W-1:0] cap_rd_q;
    logic [2:0]           cap_f3_q;

    logic                 wb_valid_q, wb_rw_q, exc_q;
    logic [REGADDR_W-1:0] wb_rd_q;
    logic [XLEN-1:0]      wb_data_q, exc_addr_q;

    logic                 is_mem, legal, new_req;
    logic [XLEN-1:0]      ld_ext;

    lsu_load_extend u_ext (
        .rdata_i  (dmem_rdata),
        .offset_i (cap_addr_q[1:0]),
        .funct3_i (cap_f3_q),
        .data_o   (ld_ext)
    );

    // In IDLE the request is driven straight from ex_*; later states replay the captured copy.
    always_comb begin
        is_mem  = ex_mem_read | ex_mem_write;
        legal   = lsu_legal(ex_mem_read, ex_mem_write, ex_funct3, ex_alu_res[1:0]);
        new_req = (state_q == IDLE) && ex_valid && is_mem && legal;

        dmem_req   = new_req || (state_q == REQ);
        dmem_we    = ex_mem_write;
        dmem_addr  = {ex_alu_res[XLEN-1:2], 2'b00};
        dmem_wdata = st_wdata(ex_funct3, ex_rs2_data);
        dmem_wstrb = st_wstrb(ex_funct3, ex_alu_res[1:0]);
        if (state_q != IDLE) begin
            dmem_we    = cap_we_q;
            dmem_addr  = {cap_addr_q[XLEN-1:2], 2'b00};
            dmem_wdata = cap_wdata_q;
            dmem_wstrb = cap_wstrb_q;
        end

        case (state_q)
            IDLE:    stall_out = new_req && !(ex_mem_write && dmem_ready);
            REQ:     stall_out = !(dmem_ready && cap_we_q);
            WAIT_RD: stall_out = !dmem_rvalid;
            default: stall_out = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cap_we_q    <= 1'b0;
            cap_rw_q    <= 1'b0;
            cap_m2r_q   <= 1'b0;
            cap_addr_q  <= '0;
            cap_wdata_q <= '0;
            cap_wstrb_q <= '0;
            cap_rd_q    <= '0;
            cap_f3_q    <= '0;
            wb_valid_q  <= 1'b0;
            wb_rw_q     <= 1'b0;
            wb_rd_q     <= '0;
            wb_data_q   <= '0;
            exc_q       <= 1'b0;
            exc_addr_q  <= '0;
        end else begin
            wb_valid_q <= 1'b0;
            wb_rw_q    <= 1'b0;
            exc_q      <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (ex_valid && !is_mem) begin
                        wb_valid_q <= 1'b1;
                        wb_rw_q    <= ex_reg_write && (ex_rd != '0);
                        wb_rd_q    <= ex_rd;
                        wb_data_q  <= ex_alu_res;
                    end else if (ex_valid && !legal) begin
                        exc_q      <= 1'b1;
                        exc_addr_q <= ex_alu_res;
                    end else if (new_req) begin
                        cap_we_q    <= ex_mem_write;
                        cap_rw_q    <= ex_reg_write;
                        cap_m2r_q   <= ex_mem_to_reg;
                        cap_addr_q  <= ex_alu_res;
                        cap_wdata_q <= dmem_wdata;
                        cap_wstrb_q <= dmem_wstrb;
                        cap_rd_q    <= ex_rd;
                        cap_f3_q    <= ex_funct3;
                        if (ex_mem_write && dmem_ready) begin
                            wb_valid_q <= 1'b1;
                            wb_rd_q    <= ex_rd;
                            wb_data_q  <= ex_alu_res;
                        end else if (dmem_ready) begin
                            state_q <= WAIT_RD;
                        end else begin
                            state_q <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (dmem_ready && cap_we_q) begin
                        wb_valid_q <= 1'b1;
                        wb_rd_q    <= cap_rd_q;
                        wb_data_q  <= cap_addr_q;
                        state_q    <= IDLE;
                    end else if (dmem_ready) begin
                        state_q <= WAIT_RD;
                    end
                end
                WAIT_RD: begin
                    if (dmem_rvalid) begin
                        wb_valid_q <= 1'b1;
                        wb_rw_q    <= cap_rw_q && (cap_rd_q != '0);
                        wb_rd_q    <= cap_rd_q;
                        wb_data_q  <= cap_m2r_q ? ld_ext : cap_addr_q;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign wb_valid     = wb_valid_q;
    assign wb_reg_write = wb_rw_q;
    assign wb_rd        = wb_rd_q;
    assign wb_data      = wb_data_q;
    assign access_exc   = exc_q;
    assign exc_addr     = exc_addr_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed-vector bench for mem_stage_lsu with a queue-based write-back scoreboard.
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ex_valid = 0, ex_mem_read = 0, ex_mem_write = 0, ex_mem_to_reg = 0, ex_reg_write = 0;
    logic [31:0] ex_alu_res = 0, ex_rs2_data = 0;
    logic [4:0]  ex_rd = 0;
    logic [2:0]  ex_funct3 = 0;
    logic        dmem_ready = 0, dmem_rvalid = 0;
    logic [31:0] dmem_rdata = 0;

    logic        stall_out, dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        wb_valid, wb_reg_write, access_exc;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data, exc_addr;

    mem_stage_lsu #(.XLEN(32), .REGADDR_W(5)) dut (
        .clk(clk), .reset(reset),
        .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_reg_write(ex_reg_write),
        .ex_alu_res(ex_alu_res), .ex_rs2_data(ex_rs2_data), .ex_rd(ex_rd), .ex_funct3(ex_funct3),
        .stall_out(stall_out), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_ready(dmem_ready),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
        .access_exc(access_exc), .exc_addr(exc_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_exc;
        bit          chk_data;
        logic        rw;
        logic [4:0]  rd;
        logic [31:0] val;
    } exp_t;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input bit is_exc, input bit chk_data, input logic rw,
                                input logic [4:0] rd, input logic [31:0] val);
        exp_t e;
        e.is_exc = is_exc; e.chk_data = chk_data; e.rw = rw; e.rd = rd; e.val = val;
        return e;
    endfunction

    // Monitor: every write-back or exception pulse must match the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && (wb_valid || access_exc)) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_output", {30'b0, wb_valid, access_exc}, 32'h0);
                end else begin
                    e = sbq.pop_front();
                    if (e.is_exc) begin
                        chk("exc_pulse", {31'b0, access_exc}, 32'h1);
                        chk("exc_addr", exc_addr, e.val);
                        chk("exc_wb_valid", {31'b0, wb_valid}, 32'h0);
                        chk("exc_wb_reg_write", {31'b0, wb_reg_write}, 32'h0);
                    end else begin
                        chk("wb_valid", {31'b0, wb_valid}, 32'h1);
                        chk("wb_no_exc", {31'b0, access_exc}, 32'h0);
                        chk("wb_reg_write", {31'b0, wb_reg_write}, {31'b0, e.rw});
                        if (e.chk_data) begin
                            chk("wb_rd", {27'b0, wb_rd}, {27'b0, e.rd});
                            chk("wb_data", wb_data, e.val);
                        end
                    end
                end
            end
        end
    end

    task automatic clear_ex();
        ex_valid = 0; ex_mem_read = 0; ex_mem_write = 0; ex_mem_to_reg = 0; ex_reg_write = 0;
        ex_alu_res = 0; ex_rs2_data = 0; ex_rd = 0; ex_funct3 = 0;
    endtask

    task automatic drive_ex(input logic rd_en, input logic wr_en, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] rs2,
                            input logic [4:0] rd, input logic rw);
        ex_valid = 1; ex_mem_read = rd_en; ex_mem_write = wr_en; ex_mem_to_reg = rd_en;
        ex_reg_write = rw; ex_alu_res = addr; ex_rs2_data = rs2; ex_rd = rd; ex_funct3 = f3;
    endtask

    task automatic do_alu(input logic [31:0] res, input logic [4:0] rd, input logic rw, input logic exp_rw);
        drive_ex(0, 0, 3'b000, res, 32'h0, rd, rw);
        #2;
        chk("alu_stall", {31'b0, stall_out}, 32'h0);
        chk("alu_no_req", {31'b0, dmem_req}, 32'h0);
        sbq.push_back(mk(0, 1, exp_rw, rd, res));
        @(posedge clk); #1;
        clear_ex();
    endtask

    task automatic do_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rs2,
                            input int ready_delay, input logic [31:0] exp_addr,
                            input logic [3:0] exp_wstrb, input logic [31:0] exp_wdata);
        int stalls = 0;
        drive_ex(0, 1, f3, addr, rs2, 5'd0, 1'b0);
        for (int c = 0; c <= ready_delay; c++) begin
            dmem_ready = (c == ready_delay);
            #2;
            chk("st_req", {31'b0, dmem_req}, 32'h1);
            chk("st_we", {31'b0, dmem_we}, 32'h1);
            chk("st_addr", dmem_addr, exp_addr);
            chk("st_wstrb", {28'b0, dmem_wstrb}, {28'b0, exp_wstrb});
            chk("st_wdata", dmem_wdata, exp_wdata);
            if (stall_out) stalls++;
            if (c == ready_delay) sbq.push_back(mk(0, 0, 1'b0, 5'd0, 32'h0));
            @(posedge clk); #1;
        end
        dmem_ready = 0;
        clear_ex();
        chk("st_stall_cycles", stalls, ready_delay);
    endtask

    task automatic do_load(input logic [2:0] f3, input logic [31:0] addr, input logic [4:0] rd,
                           input logic rw, input int ready_delay, input int lat,
                           input logic [31:0] rdata, input logic [31:0] exp_data,
                           input logic exp_rw, input int exp_stalls);
        int stalls = 0;
        drive_ex(1, 0, f3, addr, 32'h0, rd, rw);
        for (int c = 0; c <= ready_delay; c++) begin
            dmem_ready = (c == ready_delay);
            #2;
            chk("ld_req", {31'b0, dmem_req}, 32'h1);
            chk("ld_we", {31'b0, dmem_we}, 32'h0);
            chk("ld_addr", dmem_addr, {addr[31:2], 2'b00});
            if (stall_out) stalls++;
            @(posedge clk); #1;
        end
        dmem_ready = 0;
        for (int c = 1; c <= lat; c++) begin
            dmem_rvalid = (c == lat);
            dmem_rdata  = (c == lat) ? rdata : 32'h5A5A5A5A;
            #2;
            chk("ld_wait_no_req", {31'b0, dmem_req}, 32'h0);
            if (stall_out) stalls++;
            if (c == lat) sbq.push_back(mk(0, 1, exp_rw, rd, exp_data));
            @(posedge clk); #1;
        end
        dmem_rvalid = 0;
        dmem_rdata  = 0;
        clear_ex();
        chk("ld_stall_cycles", stalls, exp_stalls);
    endtask

    task automatic do_illegal(input logic rd_en, input logic wr_en, input logic [2:0] f3,
                              input logic [31:0] addr);
        drive_ex(rd_en, wr_en, f3, addr, 32'h12345678, 5'd3, 1'b1);
        dmem_ready = 1;
        #2;
        chk("ill_no_req", {31'b0, dmem_req}, 32'h0);
        chk("ill_no_stall", {31'b0, stall_out}, 32'h0);
        sbq.push_back(mk(1, 1, 1'b0, 5'd0, addr));
        @(posedge clk); #1;
        dmem_ready = 0;
        clear_ex();
    endtask

    initial begin
        int waited;
        repeat (2) @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        chk("rst_wb_valid", {31'b0, wb_valid}, 32'h0);
        chk("rst_wb_reg_write", {31'b0, wb_reg_write}, 32'h0);
        chk("rst_wb_rd", {27'b0, wb_rd}, 32'h0);
        chk("rst_wb_data", wb_data, 32'h0);
        chk("rst_access_exc", {31'b0, access_exc}, 32'h0);
        chk("rst_exc_addr", exc_addr, 32'h0);
        chk("rst_dmem_req", {31'b0, dmem_req}, 32'h0);
        chk("rst_stall", {31'b0, stall_out}, 32'h0);
        @(posedge clk); #1;

        do_alu(32'h0000_1234, 5'd5, 1'b1, 1'b1);
        do_alu(32'h0000_00AA, 5'd0, 1'b1, 1'b0);

        do_store(3'b000, 32'h103, 32'hAABBCCDD, 0, 32'h100, 4'b1000, 32'hDDDDDDDD);
        do_store(3'b001, 32'h102, 32'h11223344, 0, 32'h100, 4'b1100, 32'h33443344);
        do_store(3'b010, 32'h104, 32'hCAFEBABE, 1, 32'h104, 4'b1111, 32'hCAFEBABE);
        do_store(3'b000, 32'h200, 32'h0000005A, 0, 32'h200, 4'b0001, 32'h5A5A5A5A);
        do_store(3'b000, 32'h201, 32'h0000005A, 0, 32'h200, 4'b0010, 32'h5A5A5A5A);

        do_load(3'b000, 32'h102, 5'd7, 1'b1, 0, 3, 32'h0080FF00, 32'hFFFFFF80, 1'b1, 3);
        do_load(3'b100, 32'h102, 5'd7, 1'b1, 0, 3, 32'h0080FF00, 32'h00000080, 1'b1, 3);
        do_load(3'b010, 32'h200, 5'd8, 1'b1, 2, 2, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1, 4);
        do_load(3'b001, 32'h102, 5'd9, 1'b1, 0, 1, 32'hF00D1234, 32'hFFFFF00D, 1'b1, 1);
        do_load(3'b101, 32'h102, 5'd9, 1'b1, 0, 1, 32'hF00D1234, 32'h0000F00D, 1'b1, 1);
        do_load(3'b010, 32'h204, 5'd0, 1'b1, 0, 1, 32'h0BADF00D, 32'h0BADF00D, 1'b0, 1);

        do_illegal(1, 0, 3'b001, 32'h201);
        do_illegal(0, 1, 3'b010, 32'h102);
        do_illegal(0, 1, 3'b100, 32'h100);
        do_illegal(1, 0, 3'b011, 32'h100);
        do_illegal(1, 1, 3'b010, 32'h100);

        // Reset while a load waits for data; a late rvalid must be dropped.
        drive_ex(1, 0, 3'b010, 32'h300, 32'h0, 5'd4, 1'b1);
        dmem_ready = 1;
        @(posedge clk); #1;
        dmem_ready = 0;
        reset = 1;
        clear_ex();
        @(posedge clk); #1;
        reset = 0;
        dmem_rvalid = 1;
        dmem_rdata  = 32'h12345678;
        #2;
        chk("late_rv_stall", {31'b0, stall_out}, 32'h0);
        chk("late_rv_req", {31'b0, dmem_req}, 32'h0);
        @(negedge clk);
        chk("mid_rst_wb_valid", {31'b0, wb_valid}, 32'h0);
        chk("mid_rst_wb_data", wb_data, 32'h0);
        chk("mid_rst_wb_rd", {27'b0, wb_rd}, 32'h0);
        chk("mid_rst_exc_addr", exc_addr, 32'h0);
        @(posedge clk); #1;
        dmem_rvalid = 0;
        dmem_rdata  = 0;
        @(negedge clk);
        chk("late_rv_wb_valid", {31'b0, wb_valid}, 32'h0);
        chk("late_rv_stall2", {31'b0, stall_out}, 32'h0);

        waited = 0;
        while (sbq.size() != 0 && waited < 20) begin
            @(posedge clk);
            waited++;
        end
        chk("scoreboard_drained", sbq.size(), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
